// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, col/row scan counters,
// sync/blanking decode and a linear frame-buffer address for the visible area.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 10,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              pixel_tick,
  output logic [CW-1:0]     col,
  output logic [CW-1:0]     row,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              line_end,
  output logic              frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-bit divider is kept for CLK_DIV==1; it simply stays at zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  logic [DIV_W-1:0] div;
  logic             hs_window;
  logic             vs_window;

  // All decoded outputs come straight from the registered state so they line
  // up with col/row without any pipeline delay.
  always_comb begin
    pixel_tick = enable && (div == DIV_LAST);
    line_end   = pixel_tick && (col == H_LAST);
    frame_end  = line_end && (row == V_LAST);
    active     = (col < H_VIS) && (row < V_VIS);
    hs_window  = (col >= HS_START) && (col < HS_STOP);
    vs_window  = (row >= VS_START) && (row < VS_STOP);
    hsync      = hs_window ? HS_ON : ~HS_ON;
    vsync      = vs_window ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (enable) begin
      div <= pixel_tick ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pixel_tick) begin
      col <= line_end ? '0 : col + CW'(1);
      if (line_end) begin
        row <= frame_end ? '0 : row + CW'(1);
      end
    end
  end

  // Address only advances over visible pixels, so it tracks row*H_ACTIVE+col
  // through the blanking intervals; frame_end rewinds it for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
    end else if (pixel_tick) begin
      if (frame_end) begin
        pixel_addr <= '0;
      end else if (active) begin
        pixel_addr <= pixel_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 8x6 raster: a behavioural model
// queues the expected outputs for each clock and they are compared after the edge.
module tb_vga_timing_gen;

  localparam int H_ACT = 4, H_FP = 1, H_SY = 2, H_BP = 1;
  localparam int V_ACT = 3, V_FP = 1, V_SY = 1, V_BP = 1;
  localparam int DIV   = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        pixel_tick;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [19:0] pixel_addr;
  logic        line_end;
  logic        frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .CLK_DIV(DIV), .HSYNC_POL(0), .VSYNC_POL(0), .CW(10), .ADDR_W(20)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_tick(pixel_tick),
    .col(col), .row(row), .hsync(hsync), .vsync(vsync), .active(active),
    .pixel_addr(pixel_addr), .line_end(line_end), .frame_end(frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tick, c, r, hs, vs, act, le, fe, addr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int m_div = 0, m_col = 0, m_row = 0, m_addr = 0;

  int o_tick, o_col, o_row, o_hs, o_vs, o_act, o_le, o_fe, o_addr;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance the model by one clock edge for the given inputs.
  task automatic model_edge(input bit en, input bit r);
    bit last_c, last_r;
    if (r) begin
      m_div = 0; m_col = 0; m_row = 0; m_addr = 0;
    end else if (en) begin
      if (m_div == DIV - 1) begin
        last_c = (m_col == H_TOT - 1);
        last_r = (m_row == V_TOT - 1);
        if (last_c && last_r) m_addr = 0;
        else if (m_col < H_ACT && m_row < V_ACT) m_addr = (m_addr + 1) % (1 << 20);
        if (last_c) m_row = last_r ? 0 : m_row + 1;
        m_col = last_c ? 0 : m_col + 1;
        m_div = 0;
      end else begin
        m_div = m_div + 1;
      end
    end
  endtask

  task automatic step(input bit en, input bit r);
    exp_t e;
    exp_t got;
    rst    = r;
    enable = en;
    model_edge(en, r);
    e.tick = (en && m_div == DIV - 1) ? 1 : 0;
    e.c    = m_col;
    e.r    = m_row;
    e.hs   = (m_col >= H_ACT + H_FP && m_col < H_ACT + H_FP + H_SY) ? 0 : 1;
    e.vs   = (m_row >= V_ACT + V_FP && m_row < V_ACT + V_FP + V_SY) ? 0 : 1;
    e.act  = (m_col < H_ACT && m_row < V_ACT) ? 1 : 0;
    e.le   = (e.tick == 1 && m_col == H_TOT - 1) ? 1 : 0;
    e.fe   = (e.le == 1 && m_row == V_TOT - 1) ? 1 : 0;
    e.addr = m_addr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o_tick = int'(pixel_tick); o_col = int'(col); o_row = int'(row);
    o_hs = int'(hsync); o_vs = int'(vsync); o_act = int'(active);
    o_le = int'(line_end); o_fe = int'(frame_end); o_addr = int'(pixel_addr);
    got = exp_q.pop_front();
    check("pixel_tick", o_tick, got.tick);
    check("col", o_col, got.c);
    check("row", o_row, got.r);
    check("hsync", o_hs, got.hs);
    check("vsync", o_vs, got.vs);
    check("active", o_act, got.act);
    check("line_end", o_le, got.le);
    check("frame_end", o_fe, got.fe);
    check("pixel_addr", o_addr, got.addr);
    if (o_act == 1) check("addr_linear", o_addr, o_row * H_ACT + o_col);
  endtask

  task automatic run_until(input int c, input int r, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step(1'b1, 1'b0);
      if (o_col == c && o_row == r) found = 1'b1;
    end
    check("run_until_timeout", int'(found), 1);
  endtask

  initial begin
    int exp_col[4];
    int exp_tick[4];
    bit [7:0] hs_low;
    bit [5:0] vs_low;
    int le_cnt, fe_cnt, max_addr;

    rst = 1'b1;
    enable = 1'b0;
    exp_col  = '{0, 1, 1, 2};
    exp_tick = '{1, 0, 1, 0};

    // Reset, with enable both low and high
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_col", o_col, 0);
    check("rst_addr", o_addr, 0);
    check("rst_active", o_act, 1);
    check("rst_hsync", o_hs, 1);
    check("rst_vsync", o_vs, 1);
    check("rst_tick", o_tick, 0);

    // One full frame of 96 clocks from reset
    hs_low = '0; vs_low = '0;
    le_cnt = 0; fe_cnt = 0; max_addr = 0;
    for (int i = 0; i < H_TOT * V_TOT * DIV; i++) begin
      step(1'b1, 1'b0);
      if (i < 4) begin
        check("first_col", o_col, exp_col[i]);
        check("first_tick", o_tick, exp_tick[i]);
      end
      if (o_hs == 0 && o_row == 0) hs_low[o_col % 8] = 1'b1;
      if (o_vs == 0) vs_low[o_row % 6] = 1'b1;
      le_cnt += o_le;
      fe_cnt += o_fe;
      if (o_act == 1 && o_addr > max_addr) max_addr = o_addr;
      if (o_le == 1) check("line_end_col", o_col, H_TOT - 1);
    end
    check("hsync_low_cols", int'(hs_low), 8'b0110_0000);
    check("vsync_low_rows", int'(vs_low), 6'b01_0000);
    check("line_end_count", le_cnt, V_TOT);
    check("frame_end_count", fe_cnt, 1);
    check("max_addr", max_addr, H_ACT * V_ACT - 1);
    check("wrap_col", o_col, 0);
    check("wrap_row", o_row, 0);
    check("wrap_addr", o_addr, 0);

    // Enable drop at col=2,row=1
    run_until(2, 1, 200);
    check("pause_addr", o_addr, 6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("hold_col", o_col, 2);
    check("hold_row", o_row, 1);
    check("hold_addr", o_addr, 6);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("resume_col", o_col, 3);
    check("resume_addr", o_addr, 7);

    // Reset mid-frame at row=2,col=3
    run_until(3, 2, 200);
    step(1'b1, 1'b1);
    check("abort_col", o_col, 0);
    check("abort_row", o_row, 0);
    check("abort_addr", o_addr, 0);
    check("abort_hsync", o_hs, 1);
    check("abort_vsync", o_vs, 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("restart_col", o_col, 0);
    check("restart_row", o_row, 0);
    check("restart_addr", o_addr, 0);

    // Another frame with intermittent enable gaps
    for (int i = 0; i < 130; i++) step((i % 7) != 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
